// File: rtl/sweep_pkg.sv
// Shared types and defaults for the function sweep controller and its vector counter.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } sweep_state_t;

  localparam int unsigned DefNIn        = 4;
  localparam int unsigned DefNFunc      = 3;
  localparam int unsigned DefHoldCycles = 1;

  // Value of the final vector of a sweep over n_in inputs.
  function automatic int unsigned last_vec(input int unsigned n_in);
    return (32'd1 << n_in) - 32'd1;
  endfunction

endpackage

// File: rtl/sweep_vec_counter.sv
// Vector counter with clear, increment and terminal-count flag, plus the per-vector hold counter.
module sweep_vec_counter
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN        = DefNIn,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  input  logic            hold_en,
  output logic [N_IN-1:0] vec,
  output logic            tc,
  output logic            hold_done
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [N_IN-1:0]  LastVec  = N_IN'(last_vec(N_IN));
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic [HoldW-1:0] hold_q;

  assign tc        = (vec == LastVec);
  assign hold_done = (hold_q == HoldLast);

  // Advancing the vector restarts the hold window for the next vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec    <= '0;
      hold_q <= '0;
    end else if (clr) begin
      vec    <= '0;
      hold_q <= '0;
    end else if (inc) begin
      vec    <= vec + N_IN'(1);
      hold_q <= '0;
    end else if (hold_en && !hold_done) begin
      hold_q <= hold_q + HoldW'(1);
    end
  end

endmodule

// File: rtl/func_sweep_ctrl.sv
// Exhaustive vector sweep and agreement check across N_FUNC implementations of one function.
// SWEEP_STOP_ON_FAIL_EN: when defined, the first disagreement ends the sweep.
module func_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN        = DefNIn,
  parameter int unsigned N_FUNC      = DefNFunc,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_FUNC-1:0] f_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  sweep_state_t state_q;

  logic agree;
  logic stop;
  logic accept;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_hold_en;
  logic cnt_tc;
  logic cnt_hold_done;

  assign agree  = (&f_in) || !(|f_in);
  assign stop   = StopOnFail && !agree;
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  assign cnt_clr     = accept;
  assign cnt_hold_en = (state_q == StDrive);
  assign cnt_inc     = (state_q == StSample) && !cnt_tc && !stop;

  assign pass = done && (mismatch_cnt == '0);

  sweep_vec_counter #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_vec_counter (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .hold_en   (cnt_hold_en),
    .vec       (vec_out),
    .tc        (cnt_tc),
    .hold_done (cnt_hold_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      vec_valid        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q          <= StDrive;
            vec_valid        <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        StDrive: begin
          if (cnt_hold_done) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          if (!agree) begin
            mismatch_cnt <= mismatch_cnt + (N_IN + 1)'(1);
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_out;
              first_fail_valid <= 1'b1;
            end
          end
          // vec_out is left on the last (or failing) vector for inspection.
          if (cnt_tc || stop) begin
            state_q   <= StDone;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_q <= StDrive;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Self-checking bench for func_sweep_ctrl: directed and random fault masks against a vector-level model.
module tb_func_sweep_ctrl;
  import sweep_pkg::*;

  localparam int unsigned NIn   = 4;
  localparam int unsigned NFunc = 3;
  localparam int unsigned Hold  = 1;
  localparam int unsigned NVec  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NFunc-1:0] f_in;
  logic [NIn-1:0]   vec_out;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NIn:0]     mismatch_cnt;
  logic [NIn-1:0]   first_fail_vec;
  logic             first_fail_valid;

  logic [NFunc-1:0] mask [NVec];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  func_sweep_ctrl #(
    .N_IN        (NIn),
    .N_FUNC      (NFunc),
    .HOLD_CYCLES (Hold)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .f_in             (f_in),
    .vec_out          (vec_out),
    .vec_valid        (vec_valid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  // Reference function F = A&B | C^D with A the MSB of the vector.
  function automatic logic fref(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  assign f_in = {NFunc{fref(vec_out)}} ^ mask[vec_out];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mask_clean();
    for (int v = 0; v < NVec; v++) mask[v] = '0;
  endtask

  // Expected sweep outcome derived from the per-vector implementation outputs.
  task automatic model(output int mm, output int ff, output bit ffv, output int lat,
                       output int last);
    bit stop_en;
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop_en = 1'b1;
`else
    stop_en = 1'b0;
`endif
    mm = 0; ff = 0; ffv = 0;
    lat = NVec * (Hold + 1);
    last = NVec - 1;
    for (int v = 0; v < NVec; v++) begin
      logic [NFunc-1:0] outs;
      outs = {NFunc{fref(4'(v))}} ^ mask[v];
      if (outs != '0 && outs != '1) begin
        mm++;
        if (!ffv) begin
          ffv = 1'b1;
          ff  = v;
        end
        if (stop_en) begin
          lat  = (v + 1) * (Hold + 1);
          last = v;
          break;
        end
      end
    end
  endtask

  task automatic sweep(input string name, input bit poke);
    int  e_mm, e_ff, e_lat, e_last, cyc;
    bit  e_ffv, track_ok;
    model(e_mm, e_ff, e_ffv, e_lat, e_last);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_accept_busy"}, 32'(busy), 32'd1);
    check({name, "_accept_done"}, 32'(done), 32'd0);
    check({name, "_accept_mm"}, 32'(mismatch_cnt), 32'd0);
    check({name, "_accept_ffv"}, 32'(first_fail_valid), 32'd0);
    check({name, "_accept_vec"}, 32'(vec_out), 32'd0);
    cyc = 0;
    track_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (vec_out !== 4'(cyc / (Hold + 1)) || vec_valid !== 1'b1 || busy !== 1'b1)
        track_ok = 1'b0;
      if (poke) start = (cyc == 3 || cyc == 20);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check({name, "_vec_track"}, 32'(track_ok), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(e_lat));
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_pass"}, 32'(pass), 32'(e_mm == 0));
    check({name, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(e_mm));
    check({name, "_ffv"}, 32'(first_fail_valid), 32'(e_ffv));
    check({name, "_ff_vec"}, 32'(first_fail_vec), 32'(e_ff));
    check({name, "_final_vec"}, 32'(vec_out), 32'(e_last));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_valid_end"}, 32'(vec_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_vec"}, 32'(vec_out), 32'd0);
    check({name, "_valid"}, 32'(vec_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_pass"}, 32'(pass), 32'd0);
    check({name, "_mm"}, 32'(mismatch_cnt), 32'd0);
    check({name, "_ff_vec"}, 32'(first_fail_vec), 32'd0);
    check({name, "_ffv"}, 32'(first_fail_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_mask_clean();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Clean sweep.
    sweep("clean", 1'b0);

    // Single fault on implementation 2 at vector 0xB.
    set_mask_clean();
    mask[11] = 3'b100;
    sweep("single_b", 1'b0);

    // Implementation 0 inverted everywhere.
    for (int v = 0; v < NVec; v++) mask[v] = 3'b001;
    sweep("all_bad", 1'b0);

    // Implementation 1 wrong at vector 5.
    set_mask_clean();
    mask[5] = 3'b010;
    sweep("vec5", 1'b0);

    // Asynchronous reset mid-sweep, between edges.
    set_mask_clean();
    mask[2] = 3'b011;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("async_rst_hold");
    @(negedge clk);
    reset = 1'b0;
    set_mask_clean();
    sweep("after_rst", 1'b0);

    // Starts while busy are ignored; then restart from DONE with counts cleared.
    mask[7] = 3'b110;
    sweep("poke", 1'b1);
    set_mask_clean();
    sweep("restart", 1'b0);

    // Random fault patterns.
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < NVec; v++)
        mask[v] = ($urandom_range(0, 3) == 0) ? NFunc'($urandom) : '0;
      sweep($sformatf("rand%0d", r), 1'(r[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_sweep_ctrl.md
Name: func_sweep_ctrl

Overview:
Sequencer that exhaustively drives every input vector into N_FUNC parallel implementations of the same N_IN-input boolean function. It samples their outputs and checks that all implementations agree on every vector. It sits in front of the function blocks as a self-checking stimulus/compare engine and replaces a manual vector sweep with a hardware-sequenced one.

Parameters:
N_IN, 4, width of the input vector; the block sweeps 2^N_IN vectors.
N_FUNC, 3, number of implementations compared; must be at least 2.
HOLD_CYCLES, 1, settle cycles that each vector is held before sampling; must be at least 1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep
f_in  in  N_FUNC  bit k is the output of implementation k for the current vec_out
vec_out  out  N_IN  vector driven to all implementations
vec_valid  out  1  high while vec_out is being driven (DRIVE/SAMPLE states)
busy  out  1  high from start acceptance until done
done  out  1  sticky completion flag; cleared by an accepted start or by reset
pass  out  1  high only when done=1 and mismatch_cnt=0
mismatch_cnt  out  N_IN+1  number of vectors on which f_in bits disagreed
first_fail_vec  out  N_IN  first vector that disagreed
first_fail_valid  out  1  first_fail_vec holds a captured value

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; every output is 0, including vec_out, counters and flags.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 -> DRIVE. On the same edge: vec_out=0, vec_valid=1, busy=1, hold counter=0.
- DRIVE: hold counter increments each cycle. After HOLD_CYCLES cycles in DRIVE -> SAMPLE.
- SAMPLE, one cycle: agree = (f_in all ones) or (f_in all zeros).
  - If agree=0: mismatch_cnt increments.
  - If agree=0 and first_fail_valid=0: capture first_fail_vec=vec_out and set first_fail_valid=1.
  - If vec_out = 2^N_IN-1 -> DONE. Otherwise vec_out increments and the block returns to DRIVE.
- DONE: done=1, busy=0, vec_valid=0. vec_out holds its last value.
  - start=1 in DONE -> DRIVE, with mismatch_cnt, first_fail_*, done and vec_out cleared on that edge.
- start while busy is ignored; no restart, no effect on the counts.
- Latency: done rises 2^N_IN*(HOLD_CYCLES+1) cycles after the edge that accepted start. With the defaults that is 32 cycles.
- vec_out never wraps past 2^N_IN-1 during a sweep.
- mismatch_cnt maximum is 2^N_IN, so it needs no saturation.
- Reset mid-sweep aborts immediately: all results are lost and the block returns to IDLE.
- f_in is sampled only in SAMPLE; its value in every other state is don't-care.

Optional Feature:
Macro SWEEP_STOP_ON_FAIL_EN.
- Defined: a disagreement in SAMPLE goes directly to DONE. vec_out holds the failing vector, mismatch_cnt=1 and pass=0.
- Not defined: the full sweep always runs and counts every mismatch.

Decomposition:
- Package sweep_pkg holds:
  - the state enum typedef sweep_state_t (IDLE, DRIVE, SAMPLE, DONE);
  - localparam-style constants for the default N_IN, N_FUNC and HOLD_CYCLES;
  - a function computing the last-vector value 2^N_IN-1.
- One sub-module is natural: sweep_vec_counter.
  - Function: N_IN-bit vector counter with clear, increment enable and a terminal-count flag.
  - It contains the hold counter.
- The FSM and the compare/capture logic stay in func_sweep_ctrl.

Test Plan:
1. All f_in bits driven from one reference function (F = A&B | C^D on vec_out); pulse start -> done=1 exactly 32 cycles later, pass=1, mismatch_cnt=0, first_fail_valid=0.
2. f_in[2] inverted only when vec_out=4'hB -> mismatch_cnt=5'd1, first_fail_vec=4'hB, first_fail_valid=1, pass=0.
3. f_in[0] inverted on every vector -> mismatch_cnt=5'h10, first_fail_vec=4'h0, pass=0.
4. Assert reset asynchronously at cycle 10 of a sweep (between edges) -> all outputs 0 immediately and state IDLE; a later start gives a full clean 32-cycle run with pass=1.
5. Pulse start at cycles 3 and 20 of a sweep -> both ignored and done still at cycle 32; start while in DONE -> counts cleared and a new sweep completes 32 cycles later.
6. With SWEEP_STOP_ON_FAIL_EN and f_in[1] inverted at vec 4'h5 -> done at cycle 12 (6*2), vec_out=4'h5, mismatch_cnt=1, pass=0.
